// File: rtl/arp_pkg.sv
// ARP constants, tx state enum and reply byte selector shared by the ARP RX parser and reply TX.
// Optional build macro ARP_REPLY_PAD_EN: pad the reply with zero bytes to the 46-byte Ethernet minimum.
package arp_pkg;

    localparam int unsigned PAYLOAD_BYTES = 28;
`ifdef ARP_REPLY_PAD_EN
    localparam int unsigned FRAME_BYTES   = 46;
`else
    localparam int unsigned FRAME_BYTES   = PAYLOAD_BYTES;
`endif
    localparam int unsigned CNT_W         = $clog2(FRAME_BYTES);
    localparam int unsigned LAST_IDX      = FRAME_BYTES - 1;

    localparam logic [15:0] ARP_HTYPE     = 16'h0001;
    localparam logic [15:0] ARP_PTYPE     = 16'h0800;
    localparam logic [7:0]  ARP_HLEN      = 8'h06;
    localparam logic [7:0]  ARP_PLEN      = 8'h04;
    localparam logic [15:0] ARP_OPER_RQ   = 16'h0001;
    localparam logic [15:0] ARP_OPER_RESP = 16'h0002;

    localparam int unsigned ARP_SHA_OFS   = 8;
    localparam int unsigned ARP_SPA_OFS   = 14;
    localparam int unsigned ARP_THA_OFS   = 18;
    localparam int unsigned ARP_TPA_OFS   = 24;

    typedef enum logic {
        TX_IDLE = 1'b0,
        TX_SEND = 1'b1
    } tx_state_t;

    // Byte idx of an ARP reply, big-endian per field; indices past the payload are zero padding.
    function automatic logic [7:0] arp_byte(
        input logic [CNT_W-1:0] idx,
        input logic [47:0]      sha,
        input logic [31:0]      spa,
        input logic [47:0]      tha,
        input logic [31:0]      tpa
    );
        logic [8*PAYLOAD_BYTES-1:0] payload;
        int unsigned                i;
        payload = {ARP_HTYPE, ARP_PTYPE, ARP_HLEN, ARP_PLEN, ARP_OPER_RESP, sha, spa, tha, tpa};
        i = 32'(idx);
        if (i >= PAYLOAD_BYTES) begin
            return 8'h00;
        end
        return payload[8*(PAYLOAD_BYTES-1-i) +: 8];
    endfunction

endpackage

// File: rtl/arp_reply_tx.sv
// ARP reply transmitter: filters parsed requests on target IP and streams the OPER=2 payload bytewise.
// Build macro ARP_REPLY_PAD_EN (see arp_pkg) extends the frame with zero padding to 46 bytes.
module arp_reply_tx
    import arp_pkg::*;
(
    input  logic        aclk,
    input  logic        aresetn,
    input  logic        req_valid,
    input  logic [47:0] req_mac,
    input  logic [31:0] req_ip,
    input  logic [31:0] req_tpa,
    input  logic [47:0] local_mac,
    input  logic [31:0] local_ip,
    output logic [7:0]  m_tdata,
    output logic        m_tvalid,
    input  logic        m_tready,
    output logic        m_tlast,
    output logic        busy,
    output logic        req_drop,
    output logic        req_filtered
);

    tx_state_t        state, nxt_state;
    logic [CNT_W-1:0] cnt, nxt_cnt;
    logic             pend, nxt_pend;
    logic [47:0]      act_mac, nxt_act_mac, pend_mac;
    logic [31:0]      act_ip, nxt_act_ip, pend_ip;

    logic match, accept, hs, done;
    logic load_act_req, load_act_pend, load_pend, drop;

    assign match  = (req_tpa == local_ip);
    assign accept = req_valid & match;
    assign hs     = m_tvalid & m_tready;
    assign done   = hs & (cnt == CNT_W'(LAST_IDX));

    // Next-state decode; a request landing on the final handshake is chained straight into the next frame.
    always_comb begin
        nxt_state     = state;
        nxt_cnt       = cnt;
        nxt_pend      = pend;
        load_act_req  = 1'b0;
        load_act_pend = 1'b0;
        load_pend     = 1'b0;
        drop          = 1'b0;
        case (state)
            TX_IDLE: begin
                if (accept) begin
                    nxt_state    = TX_SEND;
                    nxt_cnt      = '0;
                    load_act_req = 1'b1;
                end
            end
            TX_SEND: begin
                if (hs) begin
                    nxt_cnt = CNT_W'(cnt + 1'b1);
                end
                if (done) begin
                    nxt_cnt = '0;
                    if (pend) begin
                        load_act_pend = 1'b1;
                        nxt_pend      = 1'b0;
                    end else if (accept) begin
                        load_act_req  = 1'b1;
                    end else begin
                        nxt_state     = TX_IDLE;
                    end
                end
                if (accept && !load_act_req) begin
                    if (!pend || done) begin
                        load_pend = 1'b1;
                        nxt_pend  = 1'b1;
                    end else begin
                        drop      = 1'b1;
                    end
                end
            end
            default: nxt_state = TX_IDLE;
        endcase
    end

    always_comb begin
        nxt_act_mac = act_mac;
        nxt_act_ip  = act_ip;
        if (load_act_req) begin
            nxt_act_mac = req_mac;
            nxt_act_ip  = req_ip;
        end else if (load_act_pend) begin
            nxt_act_mac = pend_mac;
            nxt_act_ip  = pend_ip;
        end
    end

    // Registered state and outputs; the next byte is precomputed so m_tdata stays registered.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state        <= TX_IDLE;
            cnt          <= '0;
            pend         <= 1'b0;
            act_mac      <= '0;
            act_ip       <= '0;
            pend_mac     <= '0;
            pend_ip      <= '0;
            m_tdata      <= '0;
            m_tvalid     <= 1'b0;
            m_tlast      <= 1'b0;
            busy         <= 1'b0;
            req_drop     <= 1'b0;
            req_filtered <= 1'b0;
        end else begin
            state    <= nxt_state;
            cnt      <= nxt_cnt;
            pend     <= nxt_pend;
            act_mac  <= nxt_act_mac;
            act_ip   <= nxt_act_ip;
            if (load_pend) begin
                pend_mac <= req_mac;
                pend_ip  <= req_ip;
            end
            m_tvalid     <= (nxt_state == TX_SEND);
            m_tlast      <= (nxt_state == TX_SEND) && (nxt_cnt == CNT_W'(LAST_IDX));
            m_tdata      <= (nxt_state == TX_SEND) ?
                            arp_byte(nxt_cnt, local_mac, local_ip, nxt_act_mac, nxt_act_ip) : 8'h00;
            busy         <= (nxt_state == TX_SEND) || nxt_pend;
            req_drop     <= drop;
            req_filtered <= req_valid && !match;
        end
    end

endmodule

// File: tb/tb_arp_reply_tx.sv
// Directed self-checking bench for arp_reply_tx; follows ARP_REPLY_PAD_EN for the expected frame length.
module tb_arp_reply_tx;

`ifdef ARP_REPLY_PAD_EN
    localparam int FRAME = 46;
`else
    localparam int FRAME = 28;
`endif

    logic        aclk = 1'b0;
    logic        aresetn;
    logic        req_valid;
    logic [47:0] req_mac;
    logic [31:0] req_ip;
    logic [31:0] req_tpa;
    logic [47:0] local_mac;
    logic [31:0] local_ip;
    logic [7:0]  m_tdata;
    logic        m_tvalid;
    logic        m_tready;
    logic        m_tlast;
    logic        busy;
    logic        req_drop;
    logic        req_filtered;

    int checks = 0;
    int errors = 0;

    logic [7:0] exp_q[$];
    logic       exp_l[$];

    // Reply header plus our SHA/SPA for local 02:00:00:00:00:01 / 192.168.0.1.
    logic [7:0] hdr [18] = '{8'h00, 8'h01, 8'h08, 8'h00, 8'h06, 8'h04, 8'h00, 8'h02,
                             8'h02, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01,
                             8'hC0, 8'hA8, 8'h00, 8'h01};

    arp_reply_tx dut (
        .aclk         (aclk),
        .aresetn      (aresetn),
        .req_valid    (req_valid),
        .req_mac      (req_mac),
        .req_ip       (req_ip),
        .req_tpa      (req_tpa),
        .local_mac    (local_mac),
        .local_ip     (local_ip),
        .m_tdata      (m_tdata),
        .m_tvalid     (m_tvalid),
        .m_tready     (m_tready),
        .m_tlast      (m_tlast),
        .busy         (busy),
        .req_drop     (req_drop),
        .req_filtered (req_filtered)
    );

    always #5 aclk = ~aclk;

    task automatic step();
        @(posedge aclk);
        #1;
    endtask

    task automatic build_frame(input logic [47:0] mac, input logic [31:0] ip);
        int base;
        base = exp_q.size();
        for (int i = 0; i < 18; i++) exp_q.push_back(hdr[i]);
        for (int k = 0; k < 6; k++) exp_q.push_back(mac[47-8*k -: 8]);
        for (int k = 0; k < 4; k++) exp_q.push_back(ip[31-8*k -: 8]);
        for (int i = 28; i < FRAME; i++) exp_q.push_back(8'h00);
        for (int i = 0; i < FRAME; i++) exp_l.push_back(i == FRAME - 1);
        if (exp_q.size() != base + FRAME) $display("build_frame size off");
    endtask

    task automatic set_req(input logic [47:0] mac, input logic [31:0] ip, input logic [31:0] tpa);
        req_valid = 1'b1;
        req_mac   = mac;
        req_ip    = ip;
        req_tpa   = tpa;
    endtask

    // Consume the queued expected bytes with no bubbles; optionally stall 3 cycles at one index.
    task automatic rx_frames(input int stall_idx);
        int n;
        n = exp_q.size();
        for (int i = 0; i < n; i++) begin
            if (i == stall_idx) begin
                m_tready = 1'b0;
                for (int s = 0; s < 3; s++) begin
                    step();
                    checks++;
                    if (m_tvalid !== 1'b1 || m_tdata !== exp_q[i] || m_tlast !== exp_l[i]) begin
                        errors++;
                        $display("FAIL stall_hold %0d: valid=%b data=%h last=%b required 1 %h %b",
                                 s, m_tvalid, m_tdata, m_tlast, exp_q[i], exp_l[i]);
                    end
                end
                m_tready = 1'b1;
            end
            checks++;
            if (m_tvalid !== 1'b1 || m_tdata !== exp_q[i] || m_tlast !== exp_l[i]) begin
                errors++;
                $display("FAIL byte_%0d: valid=%b data=%h last=%b required 1 %h %b",
                         i, m_tvalid, m_tdata, m_tlast, exp_q[i], exp_l[i]);
            end
            step();
        end
        exp_q.delete();
        exp_l.delete();
    endtask

    task automatic check_idle(input string name);
        checks++;
        if (m_tvalid !== 1'b0 || busy !== 1'b0 || m_tlast !== 1'b0) begin
            errors++;
            $display("FAIL %s: valid=%b busy=%b last=%b required 0 0 0", name, m_tvalid, busy, m_tlast);
        end
    endtask

    task automatic test_reset();
        aresetn = 1'b0;
        repeat (3) step();
        checks++;
        if (m_tvalid !== 1'b0 || m_tlast !== 1'b0 || m_tdata !== 8'h00 || busy !== 1'b0 ||
            req_drop !== 1'b0 || req_filtered !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: valid=%b last=%b data=%h busy=%b drop=%b filt=%b required all 0",
                     m_tvalid, m_tlast, m_tdata, busy, req_drop, req_filtered);
        end
        aresetn = 1'b1;
        step();
        check_idle("idle_after_reset");
    endtask

    task automatic test_basic();
        set_req(48'hAABB_CCDD_EEFF, 32'hC0A8_0002, 32'hC0A8_0001);
        step();
        req_valid = 1'b0;
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL busy_basic: busy=%b required 1", busy);
        end
        build_frame(48'hAABB_CCDD_EEFF, 32'hC0A8_0002);
        rx_frames(-1);
        check_idle("idle_after_basic");
    endtask

    task automatic test_filtered();
        set_req(48'hAABB_CCDD_EEFF, 32'hC0A8_0002, 32'hC0A8_0005);
        step();
        req_valid = 1'b0;
        checks++;
        if (req_filtered !== 1'b1) begin
            errors++;
            $display("FAIL filtered_pulse: req_filtered=%b required 1", req_filtered);
        end
        check_idle("filtered_no_tx");
        step();
        checks++;
        if (req_filtered !== 1'b0) begin
            errors++;
            $display("FAIL filtered_one_cycle: req_filtered=%b required 0", req_filtered);
        end
        check_idle("filtered_no_tx_late");
    endtask

    task automatic test_backpressure();
        set_req(48'h1122_3344_5566, 32'h0A00_0007, 32'hC0A8_0001);
        step();
        req_valid = 1'b0;
        build_frame(48'h1122_3344_5566, 32'h0A00_0007);
        rx_frames(10);
        check_idle("idle_after_backpressure");
    endtask

    task automatic test_back_to_back();
        fork
            begin
                set_req(48'hAABB_CCDD_EEFF, 32'hC0A8_0002, 32'hC0A8_0001);
                step();
                req_valid = 1'b0;
                repeat (4) step();
                set_req(48'h0A0B_0C0D_0E0F, 32'hC0A8_0033, 32'hC0A8_0001);
                step();
                req_valid = 1'b0;
                checks++;
                if (req_drop !== 1'b0 || busy !== 1'b1) begin
                    errors++;
                    $display("FAIL pend_accept: drop=%b busy=%b required 0 1", req_drop, busy);
                end
                repeat (2) step();
                set_req(48'h5A5A_5A5A_5A5A, 32'hC0A8_0044, 32'hC0A8_0001);
                step();
                req_valid = 1'b0;
                checks++;
                if (req_drop !== 1'b1) begin
                    errors++;
                    $display("FAIL drop_pulse: req_drop=%b required 1", req_drop);
                end
                step();
                checks++;
                if (req_drop !== 1'b0) begin
                    errors++;
                    $display("FAIL drop_one_cycle: req_drop=%b required 0", req_drop);
                end
            end
            begin
                build_frame(48'hAABB_CCDD_EEFF, 32'hC0A8_0002);
                build_frame(48'h0A0B_0C0D_0E0F, 32'hC0A8_0033);
                step();
                rx_frames(-1);
            end
        join
        check_idle("idle_after_b2b");
        repeat (5) step();
        check_idle("dropped_req_not_sent");
    endtask

    task automatic test_reset_mid_frame();
        int seen;
        set_req(48'hAABB_CCDD_EEFF, 32'hC0A8_0002, 32'hC0A8_0001);
        step();
        req_valid = 1'b0;
        build_frame(48'hAABB_CCDD_EEFF, 32'hC0A8_0002);
        for (int i = 0; i < 15; i++) begin
            if (i == 3) set_req(48'h0A0B_0C0D_0E0F, 32'hC0A8_0033, 32'hC0A8_0001);
            if (i == 4) req_valid = 1'b0;
            step();
        end
        checks++;
        if (m_tvalid !== 1'b1 || m_tdata !== exp_q[15] || busy !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset_byte15: valid=%b data=%h busy=%b required 1 %h 1",
                     m_tvalid, m_tdata, busy, exp_q[15]);
        end
        exp_q.delete();
        exp_l.delete();
        aresetn = 1'b0;
        step();
        check_idle("mid_frame_reset");
        aresetn = 1'b1;
        seen = 0;
        for (int c = 0; c < 60; c++) begin
            step();
            if (m_tvalid !== 1'b0 || busy !== 1'b0) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL post_reset_quiet: active_cycles=%0d required 0", seen);
        end
        test_basic();
    endtask

    initial begin
        aresetn   = 1'b0;
        req_valid = 1'b0;
        req_mac   = '0;
        req_ip    = '0;
        req_tpa   = '0;
        local_mac = 48'h0200_0000_0001;
        local_ip  = 32'hC0A8_0001;
        m_tready  = 1'b1;
        test_reset();
        test_basic();
        test_filtered();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_frame();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/arp_reply_tx.md
Name: arp_reply_tx

Overview:
- Downstream of the ARP receive parser. Consumes its one-cycle "ARP request parsed" pulse and the captured sender MAC/IP and target IP.
- Filters requests whose target IP is not ours. Emits the 28-byte ARP reply payload, OPER=2, as a byte-wide AXI-Stream toward the Ethernet frame builder.
- Holds one pending request while a reply is in flight.

Parameters:
- PAYLOAD_BYTES, 28, ARP payload length. Fixed; used for the counter width and the last-byte index.

Ports:
- aclk  in  1  clock
- aresetn  in  1  reset, synchronous, active-low
- req_valid  in  1  one-cycle pulse: ARP request parsed (from RX parser)
- req_mac  in  48  requester MAC (SHA of request); sampled on req_valid
- req_ip  in  32  requester IP (SPA of request); sampled on req_valid
- req_tpa  in  32  target IP of request; sampled on req_valid
- local_mac  in  48  our MAC, quasi-static
- local_ip  in  32  our IP, quasi-static
- m_tdata  out  8  reply byte
- m_tvalid  out  1  byte valid
- m_tready  in  1  sink ready
- m_tlast  out  1  final byte of reply
- busy  out  1  reply in flight or pending
- req_drop  out  1  one-cycle pulse: request lost, pending slot already full
- req_filtered  out  1  one-cycle pulse: req_tpa != local_ip, request ignored

Behaviour:
- Reset values: m_tvalid=0, m_tlast=0, m_tdata=0, busy=0, req_drop=0, req_filtered=0. Byte counter=0, pending flag=0, state=IDLE.
- Reset mid-frame aborts immediately: no tlast is issued and the pending request is discarded.
- Filter: on req_valid with req_tpa != local_ip, pulse req_filtered the next cycle. No other effect.
- Accepted request: req_valid with matching req_tpa.
- FSM has two states.
- IDLE:
  - On an accepted request, latch req_mac/req_ip into the active registers and go to SEND. Counter=0.
  - m_tvalid rises the cycle after req_valid (latency 1), with byte 0.
- SEND:
  - m_tvalid=1. m_tdata is selected by the counter, big-endian per field:
    - 0-1: 00 01 (HTYPE)
    - 2-3: 08 00 (PTYPE)
    - 4: 06 (HLEN)
    - 5: 04 (PLEN)
    - 6-7: 00 02 (OPER reply)
    - 8-13: local_mac (SHA)
    - 14-17: local_ip (SPA)
    - 18-23: latched req_mac (THA)
    - 24-27: latched req_ip (TPA)
  - The counter advances only when m_tvalid & m_tready. m_tdata, m_tvalid and m_tlast are held stable while m_tready=0.
  - m_tlast=1 exactly when counter == last index.
  - On the last-byte handshake:
    - If pending=1: copy pending regs into the active regs, clear pending, counter=0, stay in SEND. The next cycle carries byte 0, with no idle bubble.
    - Otherwise go to IDLE. m_tvalid=0 the next cycle.
- Accepted request while in SEND:
  - If pending=0, latch it into the pending regs and set pending=1.
  - If pending=1, keep the existing pending request and pulse req_drop the next cycle.
  - A request arriving in the same cycle as the last handshake of the current reply goes into the pending path and is honoured.
- local_mac/local_ip are read live during SEND. Changing them mid-frame is undefined.
- busy = (state==SEND) | pending, registered.

Optional Feature:
- Macro: ARP_REPLY_PAD_EN.
- Defined: append 18 zero bytes (indices 28-45) so the payload meets the 46-byte Ethernet minimum. m_tlast moves to index 45, and the counter widens to 6 bits.
- Undefined: 28 bytes, m_tlast at index 27. Padding is left to the MAC.

Decomposition:
- Package arp_pkg holds:
  - ARP_HTYPE=16'h0001, ARP_PTYPE=16'h0800, ARP_HLEN=8'h06, ARP_PLEN=8'h04, ARP_OPER_RQ=16'h0001, ARP_OPER_RESP=16'h0002.
  - The field offset constants (SHA=8, SPA=14, THA=18, TPA=24).
  - The tx state enum.
  - These constants are shared with the RX parser.
- No sub-module. The byte select is a function in arp_pkg.

Test Plan:
- local_mac=02:00:00:00:00:01, local_ip=C0A8_0001. req_valid with req_mac=AA:BB:CC:DD:EE:FF, req_ip=C0A8_0002, req_tpa=C0A8_0001, m_tready=1 → next cycle onward, 28 bytes: 00 01 08 00 06 04 00 02 02 00 00 00 00 01 C0 A8 00 01 AA BB CC DD EE FF C0 A8 00 02. tlast only on the FF..02 final byte (index 27).
- Same request with req_tpa=C0A8_0005 → req_filtered pulses once. m_tvalid stays 0 and busy stays 0.
- Backpressure: drive m_tready=0 for 3 cycles at byte 10 → m_tdata=00 is held for all 3 cycles. The frame still has 28 handshakes total.
- Three accepted requests at cycles 0, 5 and 8 (tready=1):
  - Second goes pending; third gives req_drop=1.
  - Two back-to-back frames are sent (56 consecutive valid bytes). The second frame's THA and TPA match the second request.
- Assert aresetn=0 at byte 15 with one request pending → next cycle m_tvalid=0, busy=0. No further output until a new req_valid.
- With ARP_REPLY_PAD_EN defined, repeat the first test → 46 bytes, bytes 28-45 are 00, tlast at index 45.
